// File: rtl/spec_global_history.sv
// ============================================================================
// Module   : spec_global_history
// Brief    : Speculative/committed global history with in-flight branch FIFO
//            and self-detected misprediction repair for gshare prediction.
//            Optional macro GSH_XOR_INDEX_EN selects gshare (pc ^ hist)
//            indexing; when undefined the PHT index is the history alone.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spec_global_history #(
  parameter int HIST_LEN = 8,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Dstall,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [HIST_LEN-1:0]        pc_idx,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  output logic [HIST_LEN-1:0]        spec_hist,
  output logic [HIST_LEN-1:0]        commit_hist,
  output logic [HIST_LEN-1:0]        pht_index,
  output logic                       mispredict,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic                       full,
  output logic                       hist_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0]    fifo_q;
  logic [PW-1:0]       head_q;
  logic [PW-1:0]       tail_q;
  logic [CW-1:0]       count_q;
  logic [HIST_LEN-1:0] spec_q;
  logic [HIST_LEN-1:0] commit_q;
  logic                err_q;

  logic                empty;
  logic                is_full;
  logic                push_req;
  logic                pop;
  logic                push;
  logic                mispred;
  logic                err_set;
  logic [HIST_LEN-1:0] commit_next;

  assign empty    = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign push_req = pred_valid & ~Dstall;

  // Reset masks resolution so mispredict cannot fire while state is being cleared.
  assign pop         = resolve_valid & ~empty & ~reset;
  assign mispred     = pop & (resolve_taken != fifo_q[head_q]);
  assign push        = push_req & ~mispred & (~is_full | pop);
  assign commit_next = {resolve_taken, commit_q[HIST_LEN-1:1]};

  assign err_set = (push_req & is_full & ~pop) | (resolve_valid & empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      spec_q   <= '0;
      commit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (err_set)
        err_q <= 1'b1;
      if (pop)
        commit_q <= commit_next;
      if (mispred) begin
        // Repaired speculative history equals the new committed history.
        spec_q  <= commit_next;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          spec_q         <= {pred_taken, spec_q[HIST_LEN-1:1]};
          fifo_q[tail_q] <= pred_taken;
          tail_q         <= tail_q + PW'(1);
        end
        if (pop)
          head_q <= head_q + PW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

`ifdef GSH_XOR_INDEX_EN
  assign pht_index = pc_idx ^ spec_q;
`else
  logic unused_pc_idx;
  assign unused_pc_idx = ^pc_idx;
  assign pht_index     = spec_q;
`endif

  assign spec_hist   = spec_q;
  assign commit_hist = commit_q;
  assign mispredict  = mispred;
  assign inflight    = count_q;
  assign full        = is_full;
  assign hist_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spec_global_history.sv
// ============================================================================
// Module   : tb_spec_global_history
// Brief    : Directed self-checking bench for spec_global_history (HIST_LEN=4,
//            DEPTH=4); expectations follow GSH_XOR_INDEX_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spec_global_history;

  logic       clk = 1'b0;
  logic       reset;
  logic       Dstall;
  logic       pred_valid;
  logic       pred_taken;
  logic [3:0] pc_idx;
  logic       resolve_valid;
  logic       resolve_taken;
  logic [3:0] spec_hist;
  logic [3:0] commit_hist;
  logic [3:0] pht_index;
  logic       mispredict;
  logic [2:0] inflight;
  logic       full;
  logic       hist_err;

  int total = 0;
  int bad   = 0;

  spec_global_history #(.HIST_LEN(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .Dstall(Dstall),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pc_idx(pc_idx),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .spec_hist(spec_hist), .commit_hist(commit_hist), .pht_index(pht_index),
    .mispredict(mispredict), .inflight(inflight), .full(full), .hist_err(hist_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 1'b0; Dstall = 1'b0; pred_valid = 1'b0; pred_taken = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic t);
    idle(); pred_valid = 1'b1; pred_taken = t; tick();
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; tick(); tick(); idle();
  endtask

  task automatic test_reset();
    logic [3:0] exp_idx;
    idle(); reset = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1; pc_idx = 4'b1010;
    tick(); #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%b exp=0", mispredict); end
    tick(); idle();
    total++; if (spec_hist !== 4'b0000) begin bad++; $display("FAIL reset_spec got=%b exp=0000", spec_hist); end
    total++; if (commit_hist !== 4'b0000) begin bad++; $display("FAIL reset_commit got=%b exp=0000", commit_hist); end
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (hist_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", hist_err); end
`ifdef GSH_XOR_INDEX_EN
    exp_idx = 4'b1010;
`else
    exp_idx = 4'b0000;
`endif
    total++; if (pht_index !== exp_idx) begin bad++; $display("FAIL reset_pht got=%b exp=%b", pht_index, exp_idx); end
  endtask

  task automatic test_spec_shift();
    logic [3:0] exp_s [3] = '{4'b1000, 4'b1100, 4'b0110};
    logic       dir   [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      push(dir[i]);
      total++; if (spec_hist !== exp_s[i]) begin bad++; $display("FAIL shift_spec[%0d] got=%b exp=%b", i, spec_hist, exp_s[i]); end
    end
    idle();
    total++; if (commit_hist !== 4'b0000) begin bad++; $display("FAIL shift_commit got=%b exp=0000", commit_hist); end
    total++; if (inflight !== 3'd3) begin bad++; $display("FAIL shift_inflight got=%0d exp=3", inflight); end
  endtask

  task automatic test_resolve();
    logic [3:0] exp_c [3] = '{4'b1000, 4'b1100, 4'b0110};
    logic       dir   [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      idle(); resolve_valid = 1'b1; resolve_taken = dir[i]; #1;
      total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL resolve_mispredict[%0d] got=%b exp=0", i, mispredict); end
      tick();
      total++; if (commit_hist !== exp_c[i]) begin bad++; $display("FAIL resolve_commit[%0d] got=%b exp=%b", i, commit_hist, exp_c[i]); end
    end
    idle();
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL resolve_inflight got=%0d exp=0", inflight); end
    total++; if (spec_hist !== 4'b0110) begin bad++; $display("FAIL resolve_spec got=%b exp=0110", spec_hist); end
  endtask

  task automatic test_mispredict();
    do_reset();
    push(1'b1); push(1'b1); push(1'b1); idle();
    total++; if (spec_hist !== 4'b1110) begin bad++; $display("FAIL mis_spec_pre got=%b exp=1110", spec_hist); end
    // Push in the mispredict cycle must be discarded.
    resolve_valid = 1'b1; resolve_taken = 1'b0; pred_valid = 1'b1; pred_taken = 1'b1; #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", mispredict); end
    tick(); idle();
    total++; if (spec_hist !== 4'b0000) begin bad++; $display("FAIL mis_spec got=%b exp=0000", spec_hist); end
    total++; if (commit_hist !== 4'b0000) begin bad++; $display("FAIL mis_commit got=%b exp=0000", commit_hist); end
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL mis_inflight got=%0d exp=0", inflight); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL mis_full got=%b exp=0", full); end
  endtask

  task automatic test_full();
    push(1'b1); push(1'b0); push(1'b1); push(1'b1); idle();
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
    total++; if (spec_hist !== 4'b1101) begin bad++; $display("FAIL full_spec got=%b exp=1101", spec_hist); end
    total++; if (hist_err !== 1'b0) begin bad++; $display("FAIL full_err_pre got=%b exp=0", hist_err); end
    push(1'b0); idle();
    total++; if (spec_hist !== 4'b1101) begin bad++; $display("FAIL ovf_spec got=%b exp=1101", spec_hist); end
    total++; if (inflight !== 3'd4) begin bad++; $display("FAIL ovf_inflight got=%0d exp=4", inflight); end
    total++; if (hist_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b exp=1", hist_err); end
    pred_valid = 1'b1; pred_taken = 1'b0; resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL pp_mispredict got=%b exp=0", mispredict); end
    tick(); idle();
    total++; if (spec_hist !== 4'b0110) begin bad++; $display("FAIL pp_spec got=%b exp=0110", spec_hist); end
    total++; if (commit_hist !== 4'b1000) begin bad++; $display("FAIL pp_commit got=%b exp=1000", commit_hist); end
    total++; if (inflight !== 3'd4) begin bad++; $display("FAIL pp_inflight got=%0d exp=4", inflight); end
  endtask

  task automatic test_stall();
    do_reset();
    push(1'b1); push(1'b1);
    idle(); Dstall = 1'b1; pred_valid = 1'b1; pred_taken = 1'b0; tick();
    total++; if (spec_hist !== 4'b1100) begin bad++; $display("FAIL stall_spec got=%b exp=1100", spec_hist); end
    total++; if (inflight !== 3'd2) begin bad++; $display("FAIL stall_inflight got=%0d exp=2", inflight); end
    resolve_valid = 1'b1; resolve_taken = 1'b1; tick();
    total++; if (spec_hist !== 4'b1100) begin bad++; $display("FAIL stall_res_spec got=%b exp=1100", spec_hist); end
    total++; if (commit_hist !== 4'b1000) begin bad++; $display("FAIL stall_res_commit got=%b exp=1000", commit_hist); end
    total++; if (inflight !== 3'd1) begin bad++; $display("FAIL stall_res_inflight got=%0d exp=1", inflight); end
    // Mispredict under stall still repairs.
    resolve_taken = 1'b0; #1;
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL stall_mis_flag got=%b exp=1", mispredict); end
    tick();
    total++; if (spec_hist !== 4'b0100) begin bad++; $display("FAIL stall_mis_spec got=%b exp=0100", spec_hist); end
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL stall_mis_inflight got=%0d exp=0", inflight); end
    total++; if (hist_err !== 1'b0) begin bad++; $display("FAIL stall_err_pre got=%b exp=0", hist_err); end
    idle(); resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL empty_res_mis got=%b exp=0", mispredict); end
    tick(); idle();
    total++; if (commit_hist !== 4'b0100) begin bad++; $display("FAIL empty_res_commit got=%b exp=0100", commit_hist); end
    total++; if (hist_err !== 1'b1) begin bad++; $display("FAIL empty_res_err got=%b exp=1", hist_err); end
  endtask

  task automatic test_index();
    logic [3:0] exp_idx;
    do_reset();
    push(1'b1); push(1'b1); idle(); pc_idx = 4'b1010; #1;
`ifdef GSH_XOR_INDEX_EN
    exp_idx = 4'b0110;
`else
    exp_idx = 4'b1100;
`endif
    total++; if (pht_index !== exp_idx) begin bad++; $display("FAIL index got=%b exp=%b", pht_index, exp_idx); end
  endtask

  task automatic test_mid_reset();
    push(1'b0); idle(); resolve_valid = 1'b1; resolve_taken = 1'b1; tick();
    idle(); reset = 1'b1; tick(); idle();
    total++; if (spec_hist !== 4'b0000) begin bad++; $display("FAIL midrst_spec got=%b exp=0000", spec_hist); end
    total++; if (commit_hist !== 4'b0000) begin bad++; $display("FAIL midrst_commit got=%b exp=0000", commit_hist); end
    total++; if (inflight !== 3'd0) begin bad++; $display("FAIL midrst_inflight got=%0d exp=0", inflight); end
  endtask

  initial begin
    idle(); pc_idx = 4'b0000;
    test_reset();
    test_spec_shift();
    test_resolve();
    test_mispredict();
    test_full();
    test_stall();
    test_index();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/spec_global_history.md
# spec_global_history

Parametrised speculative global history register (GHR) for the gshare branch predictor. It replaces the fixed 3-bit, non-recoverable history with a HIST_LEN-bit speculative history and a committed history, and tracks in-flight branches in a DEPTH-entry prediction FIFO. It detects mispredictions itself and repairs the speculative history on resolution. It sits between decode (prediction and speculative update) and execute (in-order branch resolution), and drives the PHT index.

## Interface

Parameters:
- HIST_LEN, 8, history length in bits and PHT index width; ≥2
- DEPTH, 4, maximum in-flight unresolved conditional branches; power of two, ≥2

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- Dstall  in  1  decode stall; blocks speculative update
- pred_valid  in  1  a conditional branch is predicted in decode this cycle
- pred_taken  in  1  predicted direction (1 = taken)
- pc_idx  in  HIST_LEN  PC bits used for PHT indexing
- resolve_valid  in  1  oldest in-flight branch resolves this cycle (in program order)
- resolve_taken  in  1  actual direction of the resolving branch
- spec_hist  out  HIST_LEN  speculative history
- commit_hist  out  HIST_LEN  committed (architectural) history
- pht_index  out  HIST_LEN  PHT index for the current prediction
- mispredict  out  1  resolving branch was mispredicted; combinational
- inflight  out  $clog2(DEPTH+1)  number of unresolved branches
- full  out  1  inflight == DEPTH
- hist_err  out  1  sticky protocol error flag

## Operation

- History shift: the new bit enters at the MSB. new = {bit, hist[HIST_LEN-1:1]}, so the newest outcome is at bit HIST_LEN-1.
- Push: pred_valid & !Dstall & !mispredict & (!full | pop). This shifts pred_taken into spec_hist and writes pred_taken into the FIFO tail.
- Pop: resolve_valid & (inflight != 0).
  - Reads the FIFO head (predicted bit).
  - mispredict = pop & (resolve_taken != head).
  - Shifts resolve_taken into commit_hist.
- Recovery, when mispredict = 1:
  - spec_hist ← shift(commit_hist, resolve_taken), i.e. the same value commit_hist takes.
  - The FIFO is flushed (inflight ← 0).
  - Any push in the same cycle is discarded.
- Simultaneous push and correct pop: both are performed and inflight is unchanged. This is legal even when full.
- Error conditions set hist_err = 1. It stays set until reset. State is unchanged except for any legal half of the cycle.
  - Push attempt while full with no pop: the push is dropped.
  - resolve_valid while inflight == 0: the resolve is ignored and mispredict = 0.
- Dstall gates the push only. Resolution, commit and recovery proceed during a stall.
- pht_index is combinational from pc_idx and the registered spec_hist (history before the current branch), per Configuration.
- FIFO implementation: head/tail pointers wrap modulo DEPTH, with an explicit inflight counter. Full/empty are derived from the counter, never from pointer equality.

## Timing

- Reset values:
  - spec_hist = 0, commit_hist = 0, inflight = 0
  - full = 0, hist_err = 0
  - mispredict = 0; resolve_valid is ignored while reset is high
  - pht_index follows spec_hist = 0, so it equals pc_idx with the macro defined and 0 without
- Latencies:
  - Push or pop in cycle N: spec_hist, commit_hist and inflight are updated at edge N+1.
  - mispredict is valid in cycle N, same cycle as resolve_valid. The repaired spec_hist is visible at N+1.
  - Back-to-back push every cycle is sustained, and back-to-back resolve every cycle is sustained.
- Reset asserted mid-operation: all in-flight entries are lost. The next cycle shows reset values. FIFO contents are don't-care.
- A mispredict that coincides with Dstall: recovery still occurs.

## Configuration

- Macro: GSH_XOR_INDEX_EN
- Defined: pht_index = pc_idx ^ spec_hist (gshare indexing).
- Undefined: pht_index = spec_hist (pure global GAg indexing). pc_idx is unused.
- All other behaviour is identical in both builds.

## Test plan

All scenarios use HIST_LEN=4, DEPTH=4.

- **Speculative shift:** after reset, push T, T, N on consecutive cycles → spec_hist 1000, 1100, 0110. commit_hist stays 0000. inflight = 3.
- **In-order resolve, all correct:** from the previous state, resolve T, T, N → commit_hist 1000, 1100, 0110. mispredict is never asserted. inflight = 0. spec_hist stays 0110.
- **Misprediction recovery:** push T, T, T (spec_hist 1110), then resolve N → mispredict = 1 that cycle. Next cycle spec_hist = commit_hist = 0000, inflight = 0, full = 0.
- **Full and overflow:** push 4 branches → full = 1. A 5th push with no resolve → dropped, hist_err = 1, spec_hist unchanged. Then push + correct resolve in the same cycle → both taken, inflight stays 4.
- **Stall:** Dstall = 1 with pred_valid = 1 → spec_hist and inflight unchanged. A concurrent resolve still updates commit_hist and decrements inflight. A resolve while inflight == 0 → ignored, hist_err = 1.
- **Indexing:** spec_hist = 1100, pc_idx = 1010 → pht_index = 0110 with GSH_XOR_INDEX_EN defined, and 1100 without it.
